sha1_exec_param: RTL

- Parametrised SHA-1 compression engine; successor to the fixed 32-bit, one-round-per-clock sha1_exec.
- Configurable input word width and rounds per clock; adds a double-buffered message staging area so the next 512-bit block loads while the current block compresses.
- Sits between a message framer/padder (upstream, word stream) and a digest consumer (downstream, 160-bit chaining value).

---
 rtl/sha1_pkg.sv | 80 ++++++++
 rtl/sha1_round.sv | 33 +++
 rtl/sha1_exec_param.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha1_pkg.sv
// ---------------------------------------------------------------------------
// sha1_pkg
// Shared definitions for the parametrised SHA-1 compression engine:
//   - SHA1_IV : FIPS 180 initial chaining value {H0..H4}
//   - K0..K3  : per-quarter round constants
//   - f()     : round function selected by round index (Ch / Parity / Maj)
//   - kConst(): round constant selected by round index
//   - rotl1/5/30, bswap32 : fixed bit helpers
//   - sha1_state_t : packed working state {a,b,c,d,e}, a in the MSBs
//   - sha1_fsm_t   : engine FSM states
// ---------------------------------------------------------------------------
package sha1_pkg;

    localparam logic [159:0] SHA1_IV = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
    } sha1_state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        FINAL
    } sha1_fsm_t;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Selection is per round index, so a group of chained rounds may cross
    // a 20/40/60 boundary and each instance still picks its own function.
    function automatic logic [31:0] f(input logic [6:0] round,
                                      input logic [31:0] b,
                                      input logic [31:0] c,
                                      input logic [31:0] d);
        if (round < 7'd20) begin
            return (b & c) | (~b & d);
        end else if (round < 7'd40) begin
            return b ^ c ^ d;
        end else if (round < 7'd60) begin
            return (b & c) | (b & d) | (c & d);
        end else begin
            return b ^ c ^ d;
        end
    endfunction

    function automatic logic [31:0] kConst(input logic [6:0] round);
        if (round < 7'd20) begin
            return K0;
        end else if (round < 7'd40) begin
            return K1;
        end else if (round < 7'd60) begin
            return K2;
        end else begin
            return K3;
        end
    endfunction

endpackage

// File: rtl/sha1_round.sv
// ---------------------------------------------------------------------------
// sha1_round
// One combinational SHA-1 round. The top chains RPC of these per clock.
// Ports:
//   state_i : working state {a,b,c,d,e} entering the round
//   w_i     : schedule word W[t] for this round
//   round_i : round index t (0..79), selects f and K
//   state_o : working state after the round
// ---------------------------------------------------------------------------
module sha1_round
    import sha1_pkg::*;
(
    input  sha1_state_t state_i,
    input  logic [31:0] w_i,
    input  logic [6:0]  round_i,
    output sha1_state_t state_o
);

    // Standard SHA-1 round: new a from the mix, the rest shift down with
    // b rotated into c.
    always_comb begin
        state_o.a = rotl5(state_i.a)
                  + f(round_i, state_i.b, state_i.c, state_i.d)
                  + state_i.e
                  + kConst(round_i)
                  + w_i;
        state_o.b = state_i.a;
        state_o.c = rotl30(state_i.b);
        state_o.d = state_i.c;
        state_o.e = state_i.d;
    end

endmodule

// File: rtl/sha1_exec_param.sv
// ---------------------------------------------------------------------------
// sha1_exec_param
// Parametrised SHA-1 compression engine with a double-buffered 512-bit
// message staging area: the next block can be loaded while the current one
// is compressing.
//
// Parameters:
//   DATA_W : input word width, 32 or 64 (WORDS = 512/DATA_W loads per block)
//   RPC    : rounds per clock, a divisor of 80 (NCYC = 80/RPC round cycles)
//
// Ports:
//   clk         : system clock, rising edge
//   reset       : synchronous active-high reset
//   data_in     : message word, first word of a block is bits 511 downward
//   load_in     : stage data_in this cycle
//   blk_full    : staging buffer holds WORDS words
//   start       : begin compressing the staged block (only when not busy)
//   cv          : external chaining value {H0..H4}
//   use_prev_cv : with start, chain from cv_next instead of cv
//   busy        : compression in progress
//   out_valid   : one-cycle pulse, cv_next has just been updated
//   cv_next     : resulting chaining value, held until next completion
//
// Build option:
//   SHA1_BSWAP_EN : when defined, each 32-bit lane of data_in is
//                   byte-reversed before staging (little-endian upstream).
// ---------------------------------------------------------------------------
module sha1_exec_param
    import sha1_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RPC    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_in,
    output logic              blk_full,
    input  logic              start,
    input  logic [159:0]      cv,
    input  logic              use_prev_cv,
    output logic              busy,
    output logic              out_valid,
    output logic [159:0]      cv_next
);

    localparam int WORDS = 512 / DATA_W;
    localparam int LANES = DATA_W / 32;

    // Staging buffer (always kept as 16 x 32-bit words).
    logic [31:0] stage_q [16];
    logic [31:0] stage_d [16];
    logic [4:0]  stageCnt_q, stageCnt_d;
    logic        blkFull_q, blkFull_d;

    // Engine state.
    sha1_fsm_t   state_q;
    logic        busy_q;
    logic        outValid_q;
    logic [159:0] cvNext_q;
    logic [6:0]  roundIdx_q;
    sha1_state_t work_q;
    sha1_state_t h_q;
    logic [31:0] wBuf_q [16];

    logic        startAccept;
    logic [31:0] laneIn [LANES];
    logic [3:0]  writeBase;
    logic [31:0] wWork [16];
    logic [31:0] wRound [RPC];
    logic [6:0]  roundT;
    logic [3:0]  wIdx;
    sha1_state_t chain [RPC+1];
    sha1_state_t startState;
    logic [159:0] cvSum;

    assign startAccept = start && (state_q == IDLE);

    // Split the incoming word into 32-bit lanes, most significant lane first.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
`ifdef SHA1_BSWAP_EN
            laneIn[l] = bswap32(data_in[DATA_W-1-32*l -: 32]);
`else
            laneIn[l] = data_in[DATA_W-1-32*l -: 32];
`endif
        end
    end

    // Staging next-state. A start clears the fill count; a load in the same
    // cycle lands at index 0 even if the buffer was full, because the old
    // contents have just been copied into the schedule buffer.
    always_comb begin
        stage_d    = stage_q;
        stageCnt_d = stageCnt_q;
        blkFull_d  = blkFull_q;
        writeBase  = 4'd0;
        if (startAccept) begin
            stageCnt_d = 5'd0;
            blkFull_d  = 1'b0;
        end
        if (load_in && (startAccept || !blkFull_q)) begin
            writeBase  = startAccept ? 4'd0 : 4'(stageCnt_q * LANES);
            for (int l = 0; l < LANES; l++) begin
                stage_d[writeBase + 4'(l)] = laneIn[l];
            end
            stageCnt_d = (startAccept ? 5'd0 : stageCnt_q) + 5'd1;
            blkFull_d  = (stageCnt_d == 5'(WORDS));
        end
    end

    // Staging registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                stage_q[i] <= '0;
            end
            stageCnt_q <= '0;
            blkFull_q  <= 1'b0;
        end else begin
            stage_q    <= stage_d;
            stageCnt_q <= stageCnt_d;
            blkFull_q  <= blkFull_d;
        end
    end

    // Message schedule for this cycle's RPC rounds. The 16-entry circular
    // buffer is walked in round order so later rounds in the group see
    // words produced earlier in the same cycle; slot t%16 holds W[t-16]
    // until it is overwritten with W[t].
    always_comb begin
        wWork  = wBuf_q;
        roundT = 7'd0;
        wIdx   = 4'd0;
        for (int j = 0; j < RPC; j++) begin
            roundT = roundIdx_q + 7'(j);
            wIdx   = roundT[3:0];
            if (roundT >= 7'd16) begin
                wWork[wIdx] = rotl1(wWork[wIdx + 4'd13] ^ wWork[wIdx + 4'd8]
                                  ^ wWork[wIdx + 4'd2] ^ wWork[wIdx]);
            end
            wRound[j] = wWork[wIdx];
        end
    end

    // Chain of RPC combinational rounds.
    assign chain[0] = work_q;

    for (genvar j = 0; j < RPC; j++) begin : gRound
        sha1_round uRound (
            .state_i (chain[j]),
            .w_i     (wRound[j]),
            .round_i (roundIdx_q + 7'(j)),
            .state_o (chain[j+1])
        );
    end

    assign startState = sha1_state_t'(use_prev_cv ? cvNext_q : cv);

    assign cvSum = {h_q.a + work_q.a,
                    h_q.b + work_q.b,
                    h_q.c + work_q.c,
                    h_q.d + work_q.d,
                    h_q.e + work_q.e};

    // Engine FSM: IDLE waits for start, ROUND runs NCYC groups of RPC rounds,
    // FINAL folds the working state into the chaining value and pulses
    // out_valid as it returns to IDLE (so a new start can follow at once).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            outValid_q <= 1'b0;
            cvNext_q   <= '0;
            roundIdx_q <= '0;
            work_q     <= '0;
            h_q        <= '0;
            for (int i = 0; i < 16; i++) begin
                wBuf_q[i] <= '0;
            end
        end else begin
            outValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (startAccept) begin
                        wBuf_q     <= stage_q;
                        work_q     <= startState;
                        h_q        <= startState;
                        roundIdx_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ROUND;
                    end
                end
                ROUND: begin
                    work_q <= chain[RPC];
                    wBuf_q <= wWork;
                    if (roundIdx_q == 7'(80 - RPC)) begin
                        state_q <= FINAL;
                    end else begin
                        roundIdx_q <= roundIdx_q + 7'(RPC);
                    end
                end
                FINAL: begin
                    cvNext_q   <= cvSum;
                    outValid_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign blk_full  = blkFull_q;
    assign busy      = busy_q;
    assign out_valid = outValid_q;
    assign cv_next   = cvNext_q;

endmodule
